// File: rtl/md_cart_pkg.sv
// Shared types and constants for the Mega Drive cartridge responder.
// Bank registers exist only when MD_CART_SSF2_MAPPER_EN is defined; the reset table lives here.
package md_cart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    HOLD
  } state_t;

  localparam logic [4:0] TIME_REG_BASE = 5'b01111;
  localparam logic [7:0] SRAM_WINDOW   = 8'h20;

  localparam int CTRL_SRAM_MAP = 0;
  localparam int CTRL_SRAM_WP  = 1;

  // Power-up banking is an identity map, so slot i points at physical bank i.
  localparam logic [7:0][5:0] BANK_RESET = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};

endpackage

// File: rtl/md_cart_responder_if.sv
// Cartridge-edge bus as seen by the responder; master is the board, slave is the cartridge.
interface md_cart_responder_if;

  logic [22:0] cart_address;
  logic        cart_cs;
  logic        cart_oe;
  logic        cart_lwr;
  logic        cart_uwr;
  logic        cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        cart_data_en;

  modport master (
    output cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
    input  cart_data, cart_data_en
  );

  modport slave (
    input  cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
    output cart_data, cart_data_en
  );

endinterface

// File: rtl/md_cart_mapper.sv
// Mapper control/bank registers and cartridge-to-physical address translation.
// MD_CART_SSF2_MAPPER_EN adds the writable bank registers; otherwise ROM maps linearly.
module md_cart_mapper
  import md_cart_pkg::*;
#(
  parameter int SRAM_AW = 15,
  parameter int PHYS_AW = 24
) (
  input  logic               MCLK,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [2:0]         i_index,
  input  logic [5:0]         i_data,
  input  logic [22:0]        i_addr,
  output logic [PHYS_AW-1:0] o_phys_addr,
  output logic               o_is_sram,
  output logic               o_is_unmapped,
  output logic [1:0]         o_ctrl
);

  logic [1:0]         r_ctrl;
  logic [PHYS_AW-1:0] w_romAddr;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_ctrl <= '0;
    end else if (i_wr_en && i_index == 3'd0) begin
      r_ctrl <= i_data[1:0];
    end
  end

`ifdef MD_CART_SSF2_MAPPER_EN
  logic [5:0] r_bank [8];
  logic [5:0] w_slotBank;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= BANK_RESET[i];
      end
    end else if (i_wr_en && i_index != 3'd0) begin
      r_bank[i_index] <= i_data;
    end
  end

  // Slot 0 always holds the boot vectors, so it is pinned to bank 0.
  assign w_slotBank = (i_addr[20:18] == 3'd0) ? 6'd0 : r_bank[i_addr[20:18]];
  assign w_romAddr  = PHYS_AW'({w_slotBank, i_addr[17:0]});
`else
  logic w_unusedData;

  assign w_unusedData = ^i_data[5:2];
  assign w_romAddr    = PHYS_AW'({3'b000, i_addr[20:0]});
`endif

  assign o_is_sram     = (i_addr[22:15] == SRAM_WINDOW) && r_ctrl[CTRL_SRAM_MAP];
  assign o_is_unmapped = (i_addr[22:21] != 2'b00) && !o_is_sram;
  assign o_phys_addr   = o_is_sram ? PHYS_AW'(i_addr[SRAM_AW-1:0]) : w_romAddr;
  assign o_ctrl        = r_ctrl;

endmodule

// File: rtl/md_cart_responder.sv
// Cartridge-side responder: turns cart bus accesses into backing-memory requests.
// Bank switching is present only when MD_CART_SSF2_MAPPER_EN is defined.
module md_cart_responder
  import md_cart_pkg::*;
#(
  parameter int SRAM_AW = 15,
  parameter int PHYS_AW = 24
) (
  input  logic               MCLK,
  input  logic               reset,
  md_cart_responder_if.slave cart,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic [PHYS_AW-1:0] mem_addr,
  output logic [1:0]         mem_be,
  output logic [15:0]        mem_wdata,
  input  logic               mem_ack,
  input  logic [15:0]        mem_rdata
);

  logic [22:0]        r_addr;
  logic               r_cs;
  logic               r_oe;
  logic               r_lwr;
  logic               r_uwr;
  logic               r_time;
  logic [15:0]        r_wdata;
  logic               r_rdPrev;
  logic               r_wrPrev;
  logic               r_timeWrPrev;

  state_t             r_state;
  logic [15:0]        r_cartData;
  logic               r_dataEn;
  logic               r_memReq;
  logic               r_memWe;
  logic               r_memSel;
  logic [PHYS_AW-1:0] r_memAddr;
  logic [1:0]         r_memBe;
  logic [15:0]        r_memWdata;
  logic               r_abort;

  logic               w_rdActive;
  logic               w_rdEdge;
  logic               w_wrAny;
  logic               w_wrEdge;
  logic               w_timeWr;
  logic               w_mapWr;
  logic [PHYS_AW-1:0] w_physAddr;
  logic               w_isSram;
  logic               w_isUnmapped;
  logic [1:0]         w_ctrl;

  // Bus inputs are asynchronous to MCLK; everything downstream sees only these copies.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_addr       <= '0;
      r_cs         <= 1'b0;
      r_oe         <= 1'b0;
      r_lwr        <= 1'b0;
      r_uwr        <= 1'b0;
      r_time       <= 1'b0;
      r_wdata      <= '0;
      r_rdPrev     <= 1'b0;
      r_wrPrev     <= 1'b0;
      r_timeWrPrev <= 1'b0;
    end else begin
      r_addr       <= cart.cart_address;
      r_cs         <= cart.cart_cs;
      r_oe         <= cart.cart_oe;
      r_lwr        <= cart.cart_lwr;
      r_uwr        <= cart.cart_uwr;
      r_time       <= cart.cart_time;
      r_wdata      <= cart.cart_data_wr;
      r_rdPrev     <= w_rdActive;
      r_wrPrev     <= w_wrAny;
      r_timeWrPrev <= w_timeWr;
    end
  end

  assign w_rdActive = (r_cs | r_time) & r_oe;
  assign w_rdEdge   = w_rdActive & ~r_rdPrev;
  assign w_wrAny    = r_lwr | r_uwr;
  assign w_wrEdge   = w_wrAny & ~r_wrPrev & ~r_time;
  assign w_timeWr   = r_time & r_lwr;
  assign w_mapWr    = w_timeWr & ~r_timeWrPrev & (r_addr[7:3] == TIME_REG_BASE) & (r_state == IDLE);

  md_cart_mapper #(
    .SRAM_AW (SRAM_AW),
    .PHYS_AW (PHYS_AW)
  ) u_mapper (
    .MCLK          (MCLK),
    .reset         (reset),
    .i_wr_en       (w_mapWr),
    .i_index       (r_addr[2:0]),
    .i_data        (r_wdata[5:0]),
    .i_addr        (r_addr),
    .o_phys_addr   (w_physAddr),
    .o_is_sram     (w_isSram),
    .o_is_unmapped (w_isUnmapped),
    .o_ctrl        (w_ctrl)
  );

  // A started memory request always runs to its ack; r_abort remembers a strobe dropped meanwhile.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cartData <= '0;
      r_dataEn   <= 1'b0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memSel   <= 1'b0;
      r_memAddr  <= '0;
      r_memBe    <= '0;
      r_memWdata <= '0;
      r_abort    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rdEdge) begin
            if (r_cs && !w_isUnmapped) begin
              r_memReq  <= 1'b1;
              r_memWe   <= 1'b0;
              r_memSel  <= w_isSram;
              r_memAddr <= w_physAddr;
              r_abort   <= 1'b0;
              r_state   <= RD_WAIT;
            end else begin
              r_cartData <= 16'hFFFF;
              r_dataEn   <= 1'b1;
              r_state    <= RD_DRIVE;
            end
          end else if (w_wrEdge) begin
            if (w_isSram && !w_ctrl[CTRL_SRAM_WP]) begin
              r_memReq   <= 1'b1;
              r_memWe    <= 1'b1;
              r_memSel   <= 1'b1;
              r_memAddr  <= w_physAddr;
              r_memBe    <= {r_uwr, r_lwr};
              r_memWdata <= r_wdata;
              r_state    <= WR_WAIT;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        RD_WAIT: begin
          if (!w_rdActive) begin
            r_abort <= 1'b1;
          end
          if (mem_ack) begin
            r_memReq <= 1'b0;
            if (w_rdActive && !r_abort) begin
              r_cartData <= mem_rdata;
              r_dataEn   <= 1'b1;
              r_state    <= RD_DRIVE;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        RD_DRIVE: begin
          if (!w_rdActive) begin
            r_dataEn <= 1'b0;
            r_state  <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (!w_rdActive && !w_wrAny) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cart.cart_data    = r_cartData;
  assign cart.cart_data_en = r_dataEn;
  assign mem_req           = r_memReq;
  assign mem_we            = r_memWe;
  assign mem_sel           = r_memSel;
  assign mem_addr          = r_memAddr;
  assign mem_be            = r_memBe;
  assign mem_wdata         = r_memWdata;

endmodule

// File: tb/tb_md_cart_responder.sv
// Directed bench for md_cart_responder: table of read vectors plus hand-written mapper/SRAM/abort/reset sequences.
// Expectations for banked reads follow MD_CART_SSF2_MAPPER_EN when it is defined for the build.
module tb_md_cart_responder;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        memReq;
  logic        memWe;
  logic        memSel;
  logic [23:0] memAddr;
  logic [1:0]  memBe;
  logic [15:0] memWdata;
  logic        memAck;
  logic [15:0] memRdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [22:0] addr;
    logic        cs;
    logic        tm;
    logic        expReq;
    logic [23:0] expAddr;
    logic        expSel;
    logic [15:0] ackData;
    logic [15:0] expData;
  } readVec_t;

  readVec_t readTable [8];

  md_cart_responder_if bus ();

  md_cart_responder #(
    .SRAM_AW (15),
    .PHYS_AW (24)
  ) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .cart      (bus),
    .mem_req   (memReq),
    .mem_we    (memWe),
    .mem_sel   (memSel),
    .mem_addr  (memAddr),
    .mem_be    (memBe),
    .mem_wdata (memWdata),
    .mem_ack   (memAck),
    .mem_rdata (memRdata)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [22:0] addr, input logic cs, input logic oe,
                               input logic lwr, input logic uwr, input logic tm,
                               input logic [15:0] data);
    bus.cart_address = addr;
    bus.cart_cs      = cs;
    bus.cart_oe      = oe;
    bus.cart_lwr     = lwr;
    bus.cart_uwr     = uwr;
    bus.cart_time    = tm;
    bus.cart_data_wr = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic ackAfter(input int waitCycles, input logic [15:0] data);
    tick(waitCycles);
    memRdata = data;
    memAck   = 1'b1;
    tick(1);
    memAck   = 1'b0;
    memRdata = '0;
  endtask

  task automatic mapWrite(input logic [2:0] idx, input logic [15:0] data, input logic useUwr);
    applyStimulus({15'h0, 5'b01111, idx}, 1'b0, 1'b0, ~useUwr, useUwr, 1'b1, data);
    tick(2);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(2);
  endtask

  task automatic runRead(input readVec_t v, input int id);
    applyStimulus(v.addr, v.cs, 1'b1, 1'b0, 1'b0, v.tm, '0);
    tick(2);
    checkOutput($sformatf("rd%0d.req", id), 32'(memReq), 32'(v.expReq));
    if (v.expReq) begin
      checkOutput($sformatf("rd%0d.addr", id), 32'(memAddr), 32'(v.expAddr));
      checkOutput($sformatf("rd%0d.sel", id), 32'(memSel), 32'(v.expSel));
      checkOutput($sformatf("rd%0d.we", id), 32'(memWe), 32'd0);
      checkOutput($sformatf("rd%0d.enBeforeAck", id), 32'(bus.cart_data_en), 32'd0);
      ackAfter(3, v.ackData);
      checkOutput($sformatf("rd%0d.reqDrop", id), 32'(memReq), 32'd0);
    end
    checkOutput($sformatf("rd%0d.en", id), 32'(bus.cart_data_en), 32'd1);
    checkOutput($sformatf("rd%0d.data", id), 32'(bus.cart_data), 32'(v.expData));
    applyStimulus(v.addr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(1);
    checkOutput($sformatf("rd%0d.enHold", id), 32'(bus.cart_data_en), 32'd1);
    tick(1);
    checkOutput($sformatf("rd%0d.enOff", id), 32'(bus.cart_data_en), 32'd0);
    tick(1);
  endtask

  initial begin
    logic [23:0] expBank6Addr;
    logic [23:0] expBank3Addr;
`ifdef MD_CART_SSF2_MAPPER_EN
    expBank6Addr = 24'h280005;
    expBank3Addr = 24'h540010;
`else
    expBank6Addr = 24'h180005;
    expBank3Addr = 24'h0C0010;
`endif

    readTable[0] = '{23'h040010, 1'b1, 1'b0, 1'b1, 24'h040010, 1'b0, 16'hBEEF, 16'hBEEF};
    readTable[1] = '{23'h000000, 1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 16'h1234, 16'h1234};
    readTable[2] = '{23'h600000, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 16'h0000, 16'hFFFF};
    readTable[3] = '{23'h0C0000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 16'h0000, 16'hFFFF};
    readTable[4] = '{23'h1FFFFF, 1'b1, 1'b0, 1'b1, 24'h1FFFFF, 1'b0, 16'h5A5A, 16'h5A5A};
    readTable[5] = '{23'h200000, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 16'h0000, 16'hFFFF};
    readTable[6] = '{23'h100004, 1'b1, 1'b0, 1'b1, 24'h100004, 1'b0, 16'h0F0F, 16'h0F0F};
    readTable[7] = '{23'h0A0008, 1'b1, 1'b1, 1'b1, 24'h0A0008, 1'b0, 16'h7777, 16'h7777};

    reset    = 1'b1;
    memAck   = 1'b0;
    memRdata = '0;
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(3);
    checkOutput("reset.req", 32'(memReq), 32'd0);
    checkOutput("reset.we", 32'(memWe), 32'd0);
    checkOutput("reset.sel", 32'(memSel), 32'd0);
    checkOutput("reset.addr", 32'(memAddr), 32'd0);
    checkOutput("reset.be", 32'(memBe), 32'd0);
    checkOutput("reset.wdata", 32'(memWdata), 32'd0);
    checkOutput("reset.data", 32'(bus.cart_data), 32'd0);
    checkOutput("reset.en", 32'(bus.cart_data_en), 32'd0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      runRead(readTable[i], i);
    end

    mapWrite(3'd6, 16'h000A, 1'b0);
    runRead('{23'h180005, 1'b1, 1'b0, 1'b1, expBank6Addr, 1'b0, 16'hA0A0, 16'hA0A0}, 10);

    mapWrite(3'd5, 16'h003F, 1'b1);
    runRead('{23'h140000, 1'b1, 1'b0, 1'b1, 24'h140000, 1'b0, 16'h5555, 16'h5555}, 11);

    mapWrite(3'd0, 16'h0001, 1'b0);
    runRead('{23'h100004, 1'b1, 1'b0, 1'b1, 24'h000004, 1'b1, 16'hCAFE, 16'hCAFE}, 12);

    applyStimulus(23'h100004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1200);
    tick(2);
    checkOutput("sramWr.req", 32'(memReq), 32'd1);
    checkOutput("sramWr.we", 32'(memWe), 32'd1);
    checkOutput("sramWr.be", 32'(memBe), 32'd2);
    checkOutput("sramWr.sel", 32'(memSel), 32'd1);
    checkOutput("sramWr.addr", 32'(memAddr), 32'h0004);
    checkOutput("sramWr.wdata", 32'(memWdata), 32'h1200);
    ackAfter(1, 16'h0000);
    checkOutput("sramWr.reqDrop", 32'(memReq), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(3);

    mapWrite(3'd0, 16'h0003, 1'b0);
    applyStimulus(23'h100004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1200);
    tick(2);
    checkOutput("sramWp.req", 32'(memReq), 32'd0);
    tick(2);
    checkOutput("sramWp.reqLater", 32'(memReq), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(3);

    applyStimulus(23'h000100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4321);
    tick(3);
    checkOutput("romWr.req", 32'(memReq), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(3);

    applyStimulus(23'h040010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(2);
    checkOutput("abort.req", 32'(memReq), 32'd1);
    applyStimulus(23'h040010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick(3);
    checkOutput("abort.reqHeld", 32'(memReq), 32'd1);
    checkOutput("abort.enWait", 32'(bus.cart_data_en), 32'd0);
    ackAfter(0, 16'hDEAD);
    checkOutput("abort.reqDrop", 32'(memReq), 32'd0);
    checkOutput("abort.enAck", 32'(bus.cart_data_en), 32'd0);
    tick(2);
    checkOutput("abort.enAfter", 32'(bus.cart_data_en), 32'd0);

    mapWrite(3'd3, 16'h0015, 1'b0);
    applyStimulus(23'h0C0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(2);
    checkOutput("midRst.req", 32'(memReq), 32'd1);
    checkOutput("midRst.addr", 32'(memAddr), 32'(expBank3Addr));
    reset = 1'b1;
    tick(1);
    checkOutput("midRst.reqDrop", 32'(memReq), 32'd0);
    checkOutput("midRst.addrClr", 32'(memAddr), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    tick(2);
    runRead('{23'h0C0010, 1'b1, 1'b0, 1'b1, 24'h0C0010, 1'b0, 16'h3333, 16'h3333}, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_cart_responder.md
Name: md_cart_responder

Overview:
- Cartridge-side responder for the Mega Drive cartridge bus: the slave end of the board's cart_* initiator signals.
- Decodes ROM reads, SRAM reads/writes and /TIME-region mapper writes.
- Translates each bus access into a request on a single backing-memory port (SDRAM/BRAM controller), then drives read data back onto the bus.
- Sits beside the board top, wired directly to its cart_* ports.

Parameters:
- SRAM_AW, 15, SRAM word-address width (2^15 words = 64 KB window).
- PHYS_AW, 24, backing-memory word-address width (6-bit bank + 18-bit offset).

Ports:
- MCLK  in  1  system clock, same domain as board logic.
- reset  in  1  synchronous, active-high reset.
- cart_address  in  23  68k word address A23..A1.
- cart_cs  in  1  active-high ROM chip select.
- cart_oe  in  1  active-high read strobe.
- cart_lwr  in  1  active-high low-byte write strobe.
- cart_uwr  in  1  active-high high-byte write strobe.
- cart_time  in  1  active-high /TIME region select.
- cart_data_wr  in  16  write data from the bus.
- cart_data  out  16  read data to the bus.
- cart_data_en  out  1  read-data drive enable.
- mem_req  out  1  backing-memory request; held until acknowledged.
- mem_we  out  1  1 = write.
- mem_sel  out  1  0 = ROM space, 1 = SRAM space.
- mem_addr  out  PHYS_AW  word address.
- mem_be  out  2  byte enables {upper, lower}.
- mem_wdata  out  16  write data.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  read data.

Behaviour:
- Input sampling: all cart_* inputs are registered once. Decode and edge detection use only the registered copies.
- Reset values: cart_data=0, cart_data_en=0, mem_req=0, mem_we=0, mem_sel=0, mem_addr=0, mem_be=0, mem_wdata=0, state=IDLE, ctrl=0, bank[i]=i for i=1..7.
- Mapper decode:
  - slot = A[20:18]; bank[0] is hard-wired to 0.
  - physical ROM address = {bank[slot], A[17:0]}.
  - A[22:21] != 0 is an unmapped ROM read and returns 16'hFFFF without a memory request.
- SRAM window: A[22:15] == 8'h20 and ctrl[0] = 1. SRAM address = A[SRAM_AW-1:0], mem_sel = 1.
- Mapper registers: a rising edge of (time & lwr) with A[7:3] == 5'b01111 writes register index = A[2:0]:
  - index 0 = ctrl: bit0 maps SRAM, bit1 write-protects SRAM.
  - index 1..7 = bank[index] <= data[5:0].
  - Uwr-only writes are ignored. Mapper writes complete in one cycle and never touch the mem port.
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, HOLD.
- IDLE:
  - Rising edge of (cs & oe) with a mapped address: mem_req=1 and mem_we=0, with address asserted the next cycle; go to RD_WAIT.
  - Unmapped read: cart_data=FFFF, go to RD_DRIVE directly.
  - Rising edge of (lwr | uwr) inside an enabled, unprotected SRAM window: mem_req=1, mem_we=1, mem_be={uwr,lwr}, mem_wdata latched; go to WR_WAIT.
  - Writes to ROM or protected SRAM: ignored; go to HOLD.
- RD_WAIT: on mem_ack, drop mem_req, latch cart_data=mem_rdata, go to RD_DRIVE. Latency is 2 MCLK from sampled strobe to cart_data_en, plus memory wait.
- RD_DRIVE: cart_data_en=1 while registered (cs & oe) stays high. When it goes low, cart_data_en=0 the next cycle and the FSM returns to IDLE.
- WR_WAIT: on mem_ack, drop mem_req and go to HOLD.
- HOLD: wait for all strobes low, then go to IDLE. This guarantees one action per bus cycle.
- Strobe released before ack: the request completes regardless (the backend is never abandoned). Read data is then discarded and cart_data_en is never raised.
- New strobe edges are ignored outside IDLE.
- Reset mid-operation: mem_req drops immediately and all state returns to reset values.
- Simultaneous time and cs read: cs read takes priority. A time read returns FFFF with no request.

Optional Feature:
- Macro MD_CART_SSF2_MAPPER_EN.
- Defined: bank registers are writable as described above.
- Undefined: bank registers are absent, physical address = {3'b0, A[20:0]}, and /TIME writes to index 1..7 are ignored. The ctrl register (index 0) remains.

Decomposition:
- Package md_cart_pkg holds:
  - FSM state enum.
  - TIME_REG_BASE (5'b01111) and SRAM_WINDOW (8'h20).
  - CTRL_SRAM_MAP and CTRL_SRAM_WP bit indices.
  - Reset bank table.
- One sub-module, md_cart_mapper: holds the bank/ctrl registers and the combinational address translation. Its outputs are phys_addr, is_sram, is_unmapped and ctrl.

Test Plan:
- Reset, then ROM read at A=0x040010: mem_addr=0x040010, mem_sel=0. Ack with 0xBEEF after 3 cycles, then cart_data=0xBEEF and cart_data_en=1 until oe drops; en=0 one cycle later.
- Time lwr write index 6, data 0x0A, then read A=0x180005: mem_addr={6'h0A,18'h00005}. With the macro undefined: mem_addr=0x180005.
- Ctrl=0x01, SRAM write A=0x100004, uwr only, data 0x1200: mem_we=1, mem_be=2'b10, mem_sel=1, mem_addr=0x0004. Then ctrl=0x03 and repeat: no mem_req.
- Read A=0x600000: no mem_req, cart_data=0xFFFF driven during oe.
- Read request, oe dropped before ack: mem_req is held until ack and cart_data_en stays 0. Reset asserted during RD_WAIT: mem_req=0 next cycle and bank[3]=3.
